// File: rtl/mips25_alu_pkg.sv
// Shared definitions for the MIPS25 adiabatic ALU datapath.
//   WORD_W        : operand width (16)
//   word_t        : one operand word
//   uninv_state_t : occupancy of the 2-entry recovery buffer
//   even_par()    : even-parity bit of a word (1 when the word has an odd number of ones)
package mips25_alu_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } uninv_state_t;

  function automatic logic even_par(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/cond_uninv16b_rx_if.sv
// Bus bundle for cond_uninv16b_rx.
//   Input side  : in_data, in_mask, in_valid (producer -> block), in_ready (block -> producer)
//   Output side : out_data, out_valid, word_cnt (block -> consumer), out_ready (consumer -> block)
//   out_par     : head parity, present only when COND_UNINV_PARITY_EN is defined
// Modports: slave = the recovery block, master = the surrounding logic / bench.
interface cond_uninv16b_rx_if;
  import mips25_alu_pkg::*;

  word_t      in_data;
  word_t      in_mask;
  logic       in_valid;
  logic       in_ready;
  word_t      out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] word_cnt;
`ifdef COND_UNINV_PARITY_EN
  logic       out_par;

  modport slave (
    input  in_data, in_mask, in_valid, out_ready,
    output in_ready, out_data, out_valid, word_cnt, out_par
  );
  modport master (
    output in_data, in_mask, in_valid, out_ready,
    input  in_ready, out_data, out_valid, word_cnt, out_par
  );
`else
  modport slave (
    input  in_data, in_mask, in_valid, out_ready,
    output in_ready, out_data, out_valid, word_cnt
  );
  modport master (
    output in_data, in_mask, in_valid, out_ready,
    input  in_ready, out_data, out_valid, word_cnt
  );
`endif

endinterface

// File: rtl/uninv_buf2.sv
// Two-entry FIFO with valid/ready on both sides, driven by an EMPTY/ONE/TWO
// occupancy state machine. Holds already-recovered words.
//   clkpos, rst_n           : clock and asynchronous active-low reset
//   push_data/push_valid    : incoming word; push_ready = room available
//   pop_data/pop_valid      : head word; pop_ready = consumer takes head
//   push_par/pop_par        : per-entry parity (only with COND_UNINV_PARITY_EN)
module uninv_buf2
  import mips25_alu_pkg::*;
(
  input  logic  clkpos,
  input  logic  rst_n,
  input  word_t push_data,
`ifdef COND_UNINV_PARITY_EN
  input  logic  push_par,
  output logic  pop_par,
`endif
  input  logic  push_valid,
  output logic  push_ready,
  output word_t pop_data,
  output logic  pop_valid,
  input  logic  pop_ready
);

  uninv_state_t state, state_nx;
  logic         wr_ptr, rd_ptr;
  word_t        mem [2];
`ifdef COND_UNINV_PARITY_EN
  logic         par_mem [2];
`endif

  logic push, pop;

  // Ready and valid decode only registered state, so neither side sees a
  // combinational path from the other.
  assign push_ready = (state != TWO);
  assign pop_valid  = (state != EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  assign pop_data   = mem[rd_ptr];
`ifdef COND_UNINV_PARITY_EN
  assign pop_par    = par_mem[rd_ptr];
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (push) state_nx = ONE;
      ONE:     if (push && !pop) state_nx = TWO;
               else if (pop && !push) state_nx = EMPTY;
      TWO:     if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: storage is reset because out_data must read 0 while in reset; only two entries, so this is cheap.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
`ifdef COND_UNINV_PARITY_EN
        par_mem[i] <= 1'b0;
`endif
      end
    end else begin
      state <= state_nx;
      // Push and pop in ONE: the write lands in the other slot and the read
      // pointer moves onto it, so the new word becomes the head.
      if (push) begin
        mem[wr_ptr] <= push_data;
`ifdef COND_UNINV_PARITY_EN
        par_mem[wr_ptr] <= push_par;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/cond_uninv16b_rx.sv
// Receive-side recovery of conditionally inverted 16-bit operands.
// Each accepted word is restored as in_data ^ in_mask and queued in a
// 2-entry buffer; word_cnt counts delivered words modulo 256.
//   clkpos : rising-edge clock          rst_n : asynchronous active-low reset
//   vdd/vss: supply pins, no logic function
//   bus    : cond_uninv16b_rx_if.slave (in_*/out_*/word_cnt[/out_par])
// Optional feature: COND_UNINV_PARITY_EN adds per-entry even parity on out_par.
module cond_uninv16b_rx
  import mips25_alu_pkg::*;
(
  input logic               clkpos,
  input logic               rst_n,
  input logic               vdd,
  input logic               vss,
  cond_uninv16b_rx_if.slave bus
);

  word_t      rec;
  logic       pop;
  logic [7:0] cnt_q;

  // Supply pins only exist for netlist compatibility.
  logic unused_supply;
  assign unused_supply = vdd ^ vss;

  assign rec = bus.in_data ^ bus.in_mask;

  uninv_buf2 u_buf (
    .clkpos     (clkpos),
    .rst_n      (rst_n),
    .push_data  (rec),
`ifdef COND_UNINV_PARITY_EN
    .push_par   (even_par(rec)),
    .pop_par    (bus.out_par),
`endif
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .pop_data   (bus.out_data),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready)
  );

  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clkpos or negedge rst_n) begin
    if (!rst_n)   cnt_q <= 8'h00;
    else if (pop) cnt_q <= cnt_q + 8'd1;
  end

  assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_cond_uninv16b_rx.sv
// Directed self-checking bench for cond_uninv16b_rx.
module tb_cond_uninv16b_rx;
  import mips25_alu_pkg::*;

  logic clkpos = 1'b0;
  logic rst_n  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  cond_uninv16b_rx_if bus ();

  cond_uninv16b_rx dut (
    .clkpos (clkpos),
    .rst_n  (rst_n),
    .vdd    (1'b1),
    .vss    (1'b0),
    .bus    (bus)
  );

  always #5 clkpos = ~clkpos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clkpos);
    #1;
  endtask

  task automatic drive(input logic v, input word_t d, input word_t m, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mask   = m;
    bus.out_ready = rdy;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    word_t      d, rec;

    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    #12;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  16'h0000);
    check("rst_word_cnt",  bus.word_cnt,  8'h00);
`ifdef COND_UNINV_PARITY_EN
    check("rst_out_par",   bus.out_par,   0);
`endif
    #1 rst_n = 1'b1;   // released at t=13, away from an edge

    // Single word, fully inverted.
    drive(1'b1, 16'hFF00, 16'hFFFF, 1'b1);
    step();
    check("t1_out_data",  bus.out_data,  16'h00FF);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_cnt_pre",   bus.word_cnt,  8'h00);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    check("t1_cnt_post",  bus.word_cnt,  8'h01);
    check("t1_drained",   bus.out_valid, 0);

    // Fill both entries, then try a third word.
    drive(1'b1, 16'h1234, 16'h0000, 1'b0);
    step();
    check("t2_ready_one", bus.in_ready, 1);
    drive(1'b1, 16'hABCD, 16'h0000, 1'b0);
    step();
    check("t2_ready_full", bus.in_ready, 0);
    check("t2_head",       bus.out_data, 16'h1234);
    drive(1'b1, 16'h5555, 16'h0000, 1'b0);
    step();
    check("t2_still_full", bus.in_ready, 0);
    check("t2_head_hold",  bus.out_data, 16'h1234);
    check("t2_cnt_hold",   bus.word_cnt, 8'h01);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    check("t2_second",     bus.out_data,  16'hABCD);
    check("t2_second_v",   bus.out_valid, 1);
    check("t2_ready_back", bus.in_ready,  1);
    step();
    check("t2_empty",      bus.out_valid, 0);
    check("t2_cnt",        bus.word_cnt,  8'h03);

    // Simultaneous push and pop in ONE.
    drive(1'b1, 16'h0001, 16'h0000, 1'b0);
    step();
    check("t3_head0", bus.out_data, 16'h0001);
    drive(1'b1, 16'h0F0F, 16'h00FF, 1'b1);
    step();
    check("t3_head_new", bus.out_data,  16'h0FF0);
    check("t3_valid",    bus.out_valid, 1);
    check("t3_in_ready", bus.in_ready,  1);
    check("t3_cnt",      bus.word_cnt,  8'h04);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    check("t3_empty", bus.out_valid, 0);
    check("t3_cnt2",  bus.word_cnt,  8'h05);

    // Sustained streaming: 256 pops, counter wraps through 0.
    exp_cnt = 8'h05;
    for (int i = 0; i < 256; i++) begin
      d   = {i[7:0], ~i[7:0]};
      rec = d ^ 16'h0F0F;
      drive(1'b1, d, 16'h0F0F, 1'b1);
      step();
      if (i > 0) exp_cnt = exp_cnt + 8'd1;
      check("t4_data",  bus.out_data,  rec);
      check("t4_valid", bus.out_valid, 1);
      check("t4_cnt",   bus.word_cnt,  exp_cnt);
      if (i == 251) check("t4_wrap_zero", bus.word_cnt, 8'h00);
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    check("t4_final_cnt", bus.word_cnt,  8'h05);
    check("t4_empty",     bus.out_valid, 0);

    // Asynchronous reset with two words buffered.
    drive(1'b1, 16'hCAFE, 16'h0000, 1'b0);
    step();
    drive(1'b1, 16'hBEEF, 16'h0000, 1'b0);
    step();
    check("t5_full", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_ready", bus.in_ready,  1);
    check("t5_rst_cnt",   bus.word_cnt,  8'h00);
    check("t5_rst_data",  bus.out_data,  16'h0000);
    drive(1'b1, 16'h00F0, 16'h0000, 1'b0);
    #3 rst_n = 1'b1;
    step();
    check("t5_first_push", bus.out_data, 16'h00F0);
    check("t5_one_word",   bus.in_ready, 1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    check("t5_drained", bus.out_valid, 0);

`ifdef COND_UNINV_PARITY_EN
    drive(1'b1, 16'h0007, 16'h0000, 1'b0);
    step();
    check("par_0007", bus.out_par, 1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    drive(1'b1, 16'h00FC, 16'h00FF, 1'b0);
    step();
    check("par_0003_data", bus.out_data, 16'h0003);
    check("par_0003", bus.out_par, 0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cond_uninv16b_rx.md
# cond_uninv16b_rx

Receive-side recovery stage for conditionally inverted 16-bit operands in the MIPS25 adiabatic ALU datapath. Each accepted word is un-inverted bit-wise under its mask (`rec = in_data ^ in_mask`), restoring the operand that `cond_inv`-style stages inverted. Recovered words go into a 2-entry buffer with valid/ready handshakes on both sides. A wrapping delivered-word counter is kept for bring-up and verification.

## Interface
- No parameters; width is fixed at 16 bits.
- `clkpos`  input  1  sole clock, rising-edge active.
- `rst_n`  input  1  asynchronous, active-low reset.
- `vdd`  input  1  supply pin kept for netlist compatibility; no logic function.
- `vss`  input  1  supply pin kept for netlist compatibility; no logic function.
- `in_data`  input  16  conditionally inverted operand.
- `in_mask`  input  16  per-bit inversion mask; 1 means the bit was inverted.
- `in_valid`  input  1  `in_data`/`in_mask` are valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `out_data`  output  16  recovered operand at the buffer head.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  consumer accepts the head this cycle.
- `word_cnt`  output  8  count of delivered words, modulo 256.
- `out_par`  output  1  even parity of `out_data`; present only with `COND_UNINV_PARITY_EN`.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- On push, `in_data ^ in_mask` is written to the buffer tail. The mask is not stored.
- Occupancy state machine:
  - EMPTY: push → ONE.
  - ONE: push without pop → TWO; pop without push → EMPTY; push and pop together → ONE (head replaced by the new word).
  - TWO: pop → ONE. No push is possible because `in_ready` = 0.
- `in_ready` = (state != TWO), decoded from registered state only. It never depends on `out_ready` in the same cycle, so there is no combinational ready path.
- `out_valid` = (state != EMPTY). `out_data` = head entry, taken from registers.
- Ordering is strict FIFO. A word never overtakes another word and is never dropped or duplicated.
- `word_cnt` increments by 1 on each pop and wraps 255 → 0.
- Handshake rules:
  - The producer holds `in_data`/`in_mask` stable while `in_valid` = 1 and `in_ready` = 0.
  - The block holds `out_data` stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset values: state EMPTY, `in_ready` = 1, `out_valid` = 0, `out_data` = 16'h0000, `word_cnt` = 8'h00, `out_par` = 0.
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle sustained when `out_ready` is held high.
- After 2 pushes with no pops, `in_ready` falls in the next cycle.
- Reset asserted mid-transfer empties the buffer immediately, without waiting for a clock edge.
  - Buffered words are discarded.
  - All outputs go to their reset values while `rst_n` = 0.
- On reset release, the first push can occur at the first rising edge with `rst_n` = 1.
- Entries are not cleared on pop. `out_data` after the buffer drains is don't-care, gated by `out_valid`.

## Configuration
- Macro: `COND_UNINV_PARITY_EN`.
- Defined:
  - Each entry stores one extra bit holding the even parity of its recovered word, computed at push.
  - `out_par` presents the head entry's parity bit.
- Undefined: the `out_par` port and the parity storage do not exist. All other behaviour is identical.

## Structure
- Shared package `mips25_alu_pkg` holds:
  - `WORD_W` = 16.
  - The occupancy enum `uninv_state_t` {EMPTY, ONE, TWO}.
  - Typedef `word_t` = logic [15:0].
- One sub-module, `uninv_buf2`: the 2-entry buffer plus occupancy state machine, taking the already-recovered word as input.
- The XOR recovery and `word_cnt` live in the top module.

## Test plan
- Reset, then push `in_data` = 16'hFF00, `in_mask` = 16'hFFFF with `out_ready` = 1 → next cycle `out_data` = 16'h00FF, `out_valid` = 1, `word_cnt` becomes 1.
- `out_ready` = 0; push 16'h1234 and 16'hABCD with mask 0 → `in_ready` = 0 after the second push; a third `in_valid` is not accepted. Raise `out_ready` → outputs 16'h1234 then 16'hABCD.
- State ONE with head 16'h0001; push 16'h0F0F, mask 16'h00FF, with simultaneous pop → head becomes 16'h0FF0, state stays ONE.
- 256 pops → `word_cnt` returns to 8'h00.
- Assert `rst_n` = 0 while the buffer holds 2 words → immediately `out_valid` = 0, `in_ready` = 1, `word_cnt` = 0.
- `COND_UNINV_PARITY_EN` defined: recovered word 16'h0007 → `out_par` = 1; recovered word 16'h0003 → `out_par` = 0.
